rv_data_mem_responder: RTL and testbench
========================================

// Module: rv_data_mem_responder
// PURPOSE
//  Memory-side responder for the core's data/instruction bus. Accepts one request at a time,
//  maps the core's virtual byte address onto a 2**MEM_LEN-byte on-chip RAM using the
//  split-region decrement rule, performs the read/write and returns a response after a
//  programmable wait. It is the slave end of the core's load/store request interface.
// PARAMETERS
//  XLEN            32            data width (bits)
//  MEM_LEN         20            RAM byte-address width; RAM = 2**(MEM_LEN-2) words of XLEN
//  ADDRESS_GATE    32'h000F_FFFF region split: addr < GATE -> low region, else high region
//  ADDRESS_DEC_LT  32'h0001_0094 decrement applied in the low region
//  ADDRESS_DEC_GE  32'h7FEF_FDB0 decrement applied in the high region
//  WAIT_CYCLES     1             extra cycles between grant and response (0..15)
// PORTS
//  clk_i       in   1        clock, all logic on rising edge
//  rst_i       in   1        synchronous, active-high reset
//  req_i       in   1        request valid
//  gnt_o       out  1        request accepted this cycle (combinational: req_i & state==IDLE)
//  we_i        in   1        1 = write, 0 = read
//  be_i        in   XLEN/8   byte enables (writes only)
//  addr_i      in   32       virtual byte address; bits [1:0] ignored
//  wdata_i     in   XLEN     write data
//  rvalid_o    out  1        response valid, one-cycle pulse
//  rdata_o     out  XLEN     read data, valid with rvalid_o; 0 for writes and errors
//  err_o       out  1        address fault, valid with rvalid_o
// BEHAVIOUR
//  Reset: state=IDLE, rvalid_o=0, rdata_o=0, err_o=0, wait counter=0. RAM contents not reset.
//  Translation: phys = addr_i - (addr_i < ADDRESS_GATE ? ADDRESS_DEC_LT : ADDRESS_DEC_GE),
//   32-bit unsigned. Fault if unsigned underflow (addr_i < selected decrement) or
//   phys >= 2**MEM_LEN. Word index = phys[MEM_LEN-1:2].
//  FSM IDLE -> (req_i) capture we/be/index/wdata/fault, gnt_o=1 ->
//   WAIT (if WAIT_CYCLES>0, counts WAIT_CYCLES cycles) -> RESP -> IDLE.
//   WAIT_CYCLES=0: IDLE -> RESP directly.
//  Write commits to RAM on the grant edge, per-byte by be_i; faulting writes do not commit.
//  Read data is registered from RAM and presented in RESP; rdata reflects RAM content at
//   the grant edge (single-port, no other writer can intervene).
//  RESP: rvalid_o=1 for exactly one cycle; err_o=fault; rdata_o=0 if write or fault.
//   Outside RESP rvalid_o=0, err_o=0, rdata_o=0.
//  Latency: grant at cycle T -> rvalid_o high in cycle T+1+WAIT_CYCLES.
//  gnt_o=0 in WAIT and RESP; a request held through those states is granted in the next
//   IDLE cycle (earliest T+2+WAIT_CYCLES). Max one outstanding transaction.
//  be_i=0 write: legal, no RAM change, normal response.
//  Low and high regions may alias the same RAM word; no protection, last write wins.
//  Reset mid-transaction: pending response dropped (no rvalid_o); an already granted
//   write stays committed.
// TESTING
//  WAIT_CYCLES=1: write 0xDEADBEEF be=4'hF @0x0001_0094, then read same -> gnt same cycle,
//   rvalid at T+2, rdata=0xDEADBEEF, err=0.
//  Byte write be=4'b0010 wdata=0x0000_AB00 @0x0001_0094 after above -> read gives 0xDEADABEF.
//  Alias: write 0x1234_5678 @0x7FEF_FDB4, read @0x0001_0098 -> 0x1234_5678.
//  Fault: read @0x0000_1000 (underflow) -> rvalid, err=1, rdata=0; write @0x0011_0094 in
//   low region? no: >=GATE; use @0x7FFF_FDB0 (phys 0x10_0000) -> err=1, RAM unchanged.
//  req_i held high for 6 cycles, WAIT_CYCLES=0 -> gnt pulses every 2 cycles, rvalid 1 cycle later.
//  rst_i asserted during WAIT of a read -> no rvalid; state IDLE next cycle; prior write intact.

Source files
------------

// File: rtl/rv_data_mem_responder.sv
// Slave end of the core's load/store bus: translates the virtual byte address onto an
// on-chip RAM, performs one read/write at a time and answers after a programmable wait.
module rv_data_mem_responder #(
    parameter int          XLEN           = 32,
    parameter int          MEM_LEN        = 20,
    parameter logic [31:0] ADDRESS_GATE   = 32'h000F_FFFF,
    parameter logic [31:0] ADDRESS_DEC_LT = 32'h0001_0094,
    parameter logic [31:0] ADDRESS_DEC_GE = 32'h7FEF_FDB0,
    parameter int          WAIT_CYCLES    = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic                we_i,
    input  logic [XLEN/8-1:0]   be_i,
    input  logic [31:0]         addr_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic                rvalid_o,
    output logic [XLEN-1:0]     rdata_o,
    output logic                err_o
);

    localparam int          NBYTES     = XLEN / 8;
    localparam int          WORDS      = 2 ** (MEM_LEN - 2);
    localparam logic [31:0] PHYS_LIMIT = 32'(64'd1 << MEM_LEN);
    localparam logic [3:0]  WAIT_Q     = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Returns {fault, word_index}: split-region decrement, fault on underflow or beyond RAM.
    function automatic logic [MEM_LEN-2:0] xlate(input logic [31:0] addr);
        logic [31:0] dec;
        logic [31:0] phys;
        logic        fault;
        dec   = (addr < ADDRESS_GATE) ? ADDRESS_DEC_LT : ADDRESS_DEC_GE;
        phys  = addr - dec;
        fault = (addr < dec) || (phys >= PHYS_LIMIT);
        return {fault, phys[MEM_LEN-1:2]};
    endfunction

    logic [XLEN-1:0]    mem [0:WORDS-1];

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic               fault_q, fault_d;
    logic [XLEN-1:0]    rd_q;

    logic [MEM_LEN-2:0] xl_s;
    logic               fault_s;
    logic [MEM_LEN-3:0] idx_s;
    logic               gnt_s;
    logic               mem_we_s;

    assign xl_s     = xlate(addr_i);
    assign fault_s  = xl_s[MEM_LEN-2];
    assign idx_s    = xl_s[MEM_LEN-3:0];
    assign gnt_s    = req_i && (state_q == ST_IDLE);
    assign mem_we_s = gnt_s && we_i && !fault_s;

    assign gnt_o    = gnt_s;
    assign rvalid_o = (state_q == ST_RESP);
    assign err_o    = (state_q == ST_RESP) && fault_q;
    assign rdata_o  = ((state_q == ST_RESP) && !we_q && !fault_q) ? rd_q : {XLEN{1'b0}};

    // RAM port: byte-masked write and registered read, both on the grant edge.
    always_ff @(posedge clk_i) begin
        if (gnt_s && !we_i) begin
            rd_q <= mem[idx_s];
        end else begin
            rd_q <= rd_q;
        end
        for (int b = 0; b < NBYTES; b++) begin
            if (mem_we_s && be_i[b]) begin
                mem[idx_s][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Next-state logic and capture of the granted request's attributes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    fault_d = fault_s;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_Q == 4'd0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if ((cnt_q + 4'd1) == WAIT_Q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any pending response but leaves RAM untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_rv_data_mem_responder.sv
// Self-checking bench: reference address map and RAM model feed a response scoreboard.
module tb_rv_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    logic        req0, we0;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0;
    logic        gnt0, rvalid0, err0;
    logic [31:0] rdata0;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] model_mem [int];

    always #5 clk = ~clk;

    rv_data_mem_responder #(.WAIT_CYCLES(1)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
    );

    rv_data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .gnt_o(gnt0), .we_i(we0), .be_i(be0),
        .addr_i(addr0), .wdata_i(wdata0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
    );

    function automatic void tb_map(input logic [31:0] a, output logic f, output int idx);
        logic [31:0] d;
        logic [31:0] p;
        d   = (a < 32'h000F_FFFF) ? 32'h0001_0094 : 32'h7FEF_FDB0;
        p   = a - d;
        f   = (a < d) || (p >= 32'h0010_0000);
        idx = int'(p[19:2]);
    endfunction

    task automatic do_txn(input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d);
        logic        f;
        int          idx;
        int          cyc;
        exp_t        e;
        logic [31:0] tmp;
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        #1;
        vectors++;
        if (gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL gnt addr=%h got=%b exp=1", a, gnt);
        end
        tb_map(a, f, idx);
        e.err   = f;
        e.rdata = 32'h0;
        if (!w && !f) begin
            e.rdata = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        end
        if (w && !f) begin
            tmp = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (b[k]) tmp[8*k +: 8] = d[8*k +: 8];
            end
            model_mem[idx] = tmp;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (rvalid !== 1'b1 && cyc < 20) begin
            vectors++;
            if (rdata !== 32'h0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_out addr=%h got rdata=%h err=%b exp 0/0", a, rdata, err);
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != 2) begin
            miscompares++;
            $display("FAIL latency addr=%h got=%0d exp=2", a, cyc);
        end
        e = sb_q.pop_front();
        vectors++;
        if (rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL rdata addr=%h got=%h exp=%h", a, rdata, e.rdata);
        end
        vectors++;
        if (err !== e.err) begin
            miscompares++;
            $display("FAIL err addr=%h got=%b exp=%b", a, err, e.err);
        end
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse addr=%h rvalid got=%b exp=0", a, rvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        req0 = 1'b0; we0 = 1'b0; be0 = 4'h0; addr0 = 32'h0; wdata0 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b0 || rvalid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rvalid got=%b/%b exp=0/0", rvalid, rvalid0);
        end
        vectors++;
        if (rdata !== 32'h0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out got rdata=%h err=%b exp 0/0", rdata, err);
        end
        vectors++;
        if (gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gnt got=%b exp=0", gnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_txn(1'b1, 4'hF, 32'h0001_0094, 32'hDEAD_BEEF);
        do_txn(1'b0, 4'hF, 32'h0001_0094, 32'h0);
    endtask

    task automatic test_byte_write();
        do_txn(1'b1, 4'b0010, 32'h0001_0094, 32'h0000_AB00);
        do_txn(1'b0, 4'hF, 32'h0001_0094, 32'h0);
    endtask

    task automatic test_alias();
        do_txn(1'b1, 4'hF, 32'h7FEF_FDB4, 32'h1234_5678);
        do_txn(1'b0, 4'hF, 32'h0001_0098, 32'h0);
    endtask

    task automatic test_fault();
        do_txn(1'b0, 4'hF, 32'h0000_1000, 32'h0);
        do_txn(1'b1, 4'hF, 32'h7FFF_FDB0, 32'hFFFF_FFFF);
        do_txn(1'b0, 4'hF, 32'h0001_0094, 32'h0);
    endtask

    task automatic test_be_zero();
        do_txn(1'b1, 4'h0, 32'h0001_0094, 32'h0000_0000);
        do_txn(1'b0, 4'hF, 32'h0001_0094, 32'h0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0001_0098;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_rvalid cycle=%0d got=%b exp=0", i, rvalid);
            end
        end
        do_txn(1'b0, 4'hF, 32'h0001_0098, 32'h0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 32'h0001_0094; wdata0 = 32'h0000_0001;
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++;
            if (gnt0 !== ((i % 2) == 0)) begin
                miscompares++;
                $display("FAIL b2b_gnt cycle=%0d got=%b exp=%b", i, gnt0, (i % 2) == 0);
            end
            vectors++;
            if (rvalid0 !== ((i % 2) == 1) || err0 !== 1'b0 || rdata0 !== 32'h0) begin
                miscompares++;
                $display("FAIL b2b_resp cycle=%0d got rvalid=%b err=%b rdata=%h exp rvalid=%b",
                         i, rvalid0, err0, rdata0, (i % 2) == 1);
            end
            @(negedge clk);
        end
        we0 = 1'b0;
        #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_read_gnt got=%b exp=1", gnt0);
        end
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        vectors++;
        if (rvalid0 !== 1'b1 || rdata0 !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL b2b_read got rvalid=%b rdata=%h exp 1/00000001", rvalid0, rdata0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_alias();
        test_fault();
        test_be_zero();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
